// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared widths and sequencer state encoding for the calculator.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int SEL_N_DEF  = 16;
  localparam int OP_W_DEF   = $clog2(SEL_N_DEF);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    RESP   = ST_RESP
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/onehot_encoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_encoder
// Purpose  : Combinational op -> (1 << op); all-zero for an out-of-range op.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_encoder
  import calc_pkg::*;
#(
  parameter int SEL_N = SEL_N_DEF,
  parameter int OP_W  = $clog2(SEL_N)
) (
  input  logic [OP_W-1:0]  op,
  output logic [SEL_N-1:0] hot
);

  localparam logic [OP_W:0] SEL_LIM = (OP_W+1)'(SEL_N);

  always_comb begin
    hot = '0;
    if ({1'b0, op} < SEL_LIM) begin
      hot[op] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/opcode_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : opcode_select_sequencer
// Purpose  : Drives the one-hot result-mux select for a command opcode, waits
//            SETTLE_CYCLES, captures muxout and hands it downstream.
//            Optional STATUS_FLAGS_EN adds registered res_zero / res_neg.
// Revision : 1.0 - initial release
// ============================================================================
module opcode_select_sequencer
  import calc_pkg::*;
#(
  parameter  int DATA_W        = DATA_W_DEF,
  parameter  int SEL_N         = SEL_N_DEF,
  parameter  int SETTLE_CYCLES = 2,
  localparam int OP_W          = $clog2(SEL_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [SEL_N-1:0]  hotselect,
  input  logic [DATA_W-1:0] muxout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [OP_W-1:0]   res_op,
`ifdef STATUS_FLAGS_EN
  output logic              res_zero,
  output logic              res_neg,
`endif
  output logic              busy
);

  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [SEL_N-1:0]  r_hot;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_data;

  logic [SEL_N-1:0]  w_hot;
  logic [DATA_W-1:0] w_capture;
  logic              w_capture_en;

  onehot_encoder #(
    .SEL_N (SEL_N),
    .OP_W  (OP_W)
  ) u_enc (
    .op  (cmd_op),
    .hot (w_hot)
  );

  // An out-of-range op leaves the select at zero, so the captured value is forced to 0.
  assign w_capture    = (r_hot != '0) ? muxout : '0;
  assign w_capture_en = (r_state == SETTLE) && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hot   <= '0;
      r_op    <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_state <= SETTLE;
            r_cnt   <= CNT_LOAD;
            r_op    <= cmd_op;
            r_hot   <= w_hot;
          end
        end
        SETTLE: begin
          if (w_capture_en) begin
            r_state <= RESP;
            r_data  <= w_capture;
            r_hot   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (res_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_hot   <= '0;
        end
      endcase
    end
  end

`ifdef STATUS_FLAGS_EN
  logic r_zero;
  logic r_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_capture_en) begin
      r_zero <= (w_capture == '0);
      r_neg  <= w_capture[DATA_W-1];
    end
  end

  assign res_zero = r_zero;
  assign res_neg  = r_neg;
`endif

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign res_valid = (r_state == RESP);
  assign hotselect = r_hot;
  assign res_data  = r_data;
  assign res_op    = r_op;

endmodule
`default_nettype wire

// File: tb/tb_opcode_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_opcode_select_sequencer
// Purpose  : Self-checking bench: transaction-level model plus directed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opcode_select_sequencer;
  import calc_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int SN = SEL_N_DEF;
  localparam int OW = OP_W_DEF;
  localparam int S  = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid, cmd_ready, res_valid, res_ready, busy;
  logic [OW-1:0] cmd_op, res_op;
  logic [SN-1:0] hotselect;
  logic [DW-1:0] muxout, res_data;
  logic          cmd_valid1, cmd_ready1, res_valid1, res_ready1, busy1;
  logic [OW-1:0] cmd_op1, res_op1;
  logic [SN-1:0] hotselect1;
  logic [DW-1:0] muxout1, res_data1;
`ifdef STATUS_FLAGS_EN
  logic          res_zero, res_neg, res_zero1, res_neg1;
`endif

  logic [DW-1:0] tbl [SN];
  int            errors = 0;
  int            checks = 0;
  int            mux_n, mux_n1;

  always #5 clk = ~clk;

  opcode_select_sequencer #(.DATA_W(DW), .SEL_N(SN), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .hotselect(hotselect), .muxout(muxout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op),
`ifdef STATUS_FLAGS_EN
    .res_zero(res_zero), .res_neg(res_neg),
`endif
    .busy(busy));

  opcode_select_sequencer #(.DATA_W(DW), .SEL_N(SN), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op1), .hotselect(hotselect1), .muxout(muxout1),
    .res_valid(res_valid1), .res_ready(res_ready1), .res_data(res_data1),
    .res_op(res_op1),
`ifdef STATUS_FLAGS_EN
    .res_zero(res_zero1), .res_neg(res_neg1),
`endif
    .busy(busy1));

  // Multiplexer model: one-hot picks a table entry, zero and multi-hot give marker values.
  always_comb begin
    muxout = 32'h5A5A_0000;
    mux_n  = 0;
    for (int i = 0; i < SN; i++) begin
      if (hotselect[i]) begin
        muxout = tbl[i];
        mux_n  = mux_n + 1;
      end
    end
    if (mux_n > 1) muxout = '1;
  end

  always_comb begin
    muxout1 = 32'h5A5A_0000;
    mux_n1  = 0;
    for (int i = 0; i < SN; i++) begin
      if (hotselect1[i]) begin
        muxout1 = tbl[i];
        mux_n1  = mux_n1 + 1;
      end
    end
    if (mux_n1 > 1) muxout1 = '1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: cycles elapsed since accept decide every output.
  logic          m_active = 1'b0;
  logic          m_resp   = 1'b0;
  int            m_el     = 0;
  logic [OW-1:0] m_op     = '0;
  logic [DW-1:0] m_data   = '0;
`ifdef STATUS_FLAGS_EN
  logic          m_zero   = 1'b0;
  logic          m_neg    = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_resp   <= 1'b0;
      m_el     <= 0;
      m_op     <= '0;
      m_data   <= '0;
`ifdef STATUS_FLAGS_EN
      m_zero   <= 1'b0;
      m_neg    <= 1'b0;
`endif
    end else if (!m_active) begin
      if (cmd_valid) begin
        m_active <= 1'b1;
        m_el     <= 0;
        m_op     <= cmd_op;
      end
    end else if (!m_resp) begin
      m_el <= m_el + 1;
      if (m_el + 1 == S) begin
        m_resp <= 1'b1;
        m_data <= tbl[m_op];
`ifdef STATUS_FLAGS_EN
        m_zero <= (tbl[m_op] == 0);
        m_neg  <= tbl[m_op][DW-1];
`endif
      end
    end else if (res_ready) begin
      m_active <= 1'b0;
      m_resp   <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_cmd_ready", cmd_ready, !m_active);
      chk("m_busy", busy, m_active);
      chk("m_hotselect", hotselect, (m_active && !m_resp) ? (16'h1 << m_op) : 16'h0);
      chk("m_res_valid", res_valid, m_resp);
      chk("m_res_data", res_data, m_data);
      chk("m_res_op", res_op, m_op);
`ifdef STATUS_FLAGS_EN
      chk("m_res_zero", res_zero, m_zero);
      chk("m_res_neg", res_neg, m_neg);
`endif
    end
  end

  // Event logs used by the directed back-to-back checks.
  int            cyc = 0;
  int            acc_cyc[$];
  logic [OW-1:0] rq_op[$];
  logic [DW-1:0] rq_data[$];
  logic [SN-1:0] hot_seq[$];
  logic [SN-1:0] prev_hot = '0;

  always @(posedge clk) begin
    if (rst_n) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
      if (res_valid && res_ready) begin
        rq_op.push_back(res_op);
        rq_data.push_back(res_data);
      end
    end
  end

  always @(negedge clk) begin
    if (hotselect != prev_hot && hotselect != '0) hot_seq.push_back(hotselect);
    prev_hot <= hotselect;
  end

`ifdef STATUS_FLAGS_EN
  task automatic run_op(input logic [OW-1:0] op);
    bit seen = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = res_valid;
    end
    if (!seen) chk("flag_timeout", 0, 1);
  endtask
`endif

  initial begin
    int a0, b0, r0;
    bit done;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; res_ready = 1'b0;
    cmd_valid1 = 1'b0; cmd_op1 = '0; res_ready1 = 1'b0;
    for (int i = 0; i < SN; i++) tbl[i] = $urandom;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_hotselect", hotselect, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_op", res_op, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Op 5 through settle, then 10 cycles of backpressure.
    tbl[5] = 32'hDEADBEEF;
    cmd_valid = 1'b1; cmd_op = 4'd5;
    @(posedge clk); #2;
    cmd_valid = 1'b0; cmd_op = OW'($urandom);
    @(negedge clk);
    chk("t1_hot_e0", hotselect, 16'h0020);
    chk("t1_valid_e0", res_valid, 0);
    @(negedge clk);
    chk("t1_hot_e1", hotselect, 16'h0020);
    chk("t1_valid_e1", res_valid, 0);
    @(negedge clk);
    chk("t1_hot_e2", hotselect, 16'h0000);
    chk("t1_valid_e2", res_valid, 1);
    chk("t1_data", res_data, 32'hDEADBEEF);
    chk("t1_op", res_op, 5);
    repeat (10) @(negedge clk);
    chk("bp_valid", res_valid, 1);
    chk("bp_data", res_data, 32'hDEADBEEF);
    chk("bp_op", res_op, 5);
    chk("bp_cmd_ready", cmd_ready, 0);
    chk("bp_hot", hotselect, 0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", cmd_ready, 1);
    chk("bp_release_valid", res_valid, 0);

    // Back-to-back ops 0 then 15 with res_ready high.
    a0 = acc_cyc.size(); b0 = hot_seq.size(); r0 = rq_op.size();
    tbl[0] = $urandom; tbl[15] = $urandom;
    cmd_valid = 1'b1; cmd_op = 4'd0;
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(posedge clk); #2;
      done = (acc_cyc.size() >= a0 + 1);
    end
    cmd_op = 4'd15;
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(posedge clk); #2;
      done = (acc_cyc.size() >= a0 + 2);
    end
    cmd_valid = 1'b0;
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(posedge clk); #2;
      done = (rq_op.size() >= r0 + 2);
    end
    chk("b2b_accepts", acc_cyc.size() - a0, 2);
    chk("b2b_results", rq_op.size() - r0, 2);
    chk("b2b_hot_count", hot_seq.size() - b0, 2);
    if (acc_cyc.size() >= a0 + 2) chk("b2b_period", acc_cyc[a0+1] - acc_cyc[a0], 4);
    if (hot_seq.size() >= b0 + 2) begin
      chk("b2b_hot0", hot_seq[b0], 16'h0001);
      chk("b2b_hot1", hot_seq[b0+1], 16'h8000);
    end
    if (rq_op.size() >= r0 + 2) begin
      chk("b2b_op0", rq_op[r0], 0);
      chk("b2b_op1", rq_op[r0+1], 15);
      chk("b2b_data0", rq_data[r0], tbl[0]);
      chk("b2b_data1", rq_data[r0+1], tbl[15]);
    end

    // Reset pulsed mid-settle discards the operation.
    @(negedge clk);
    res_ready = 1'b0; cmd_valid = 1'b1; cmd_op = 4'd3;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rs_hot_before", hotselect, 16'h0008);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_hot_async", hotselect, 0);
    chk("rs_busy_async", busy, 0);
    chk("rs_ready_async", cmd_ready, 1);
    chk("rs_valid_async", res_valid, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rs_no_valid", res_valid, 0);
      chk("rs_ready", cmd_ready, 1);
    end

`ifdef STATUS_FLAGS_EN
    tbl[2] = 32'h0000_0000;
    tbl[9] = 32'h8000_0001;
    res_ready = 1'b1;
    run_op(4'd2);
    chk("flag_zero_z", res_zero, 1);
    chk("flag_zero_n", res_neg, 0);
    run_op(4'd9);
    chk("flag_neg_z", res_zero, 0);
    chk("flag_neg_n", res_neg, 1);
`endif

    // Single-cycle settle instance: op 7.
    @(negedge clk);
    tbl[7] = $urandom;
    cmd_valid1 = 1'b1; cmd_op1 = 4'd7;
    @(posedge clk); #2;
    cmd_valid1 = 1'b0;
    @(negedge clk);
    chk("s1_hot_e0", hotselect1, 16'h0080);
    chk("s1_valid_e0", res_valid1, 0);
    chk("s1_ready_e0", cmd_ready1, 0);
    @(negedge clk);
    chk("s1_valid_e1", res_valid1, 1);
    chk("s1_data", res_data1, tbl[7]);
    chk("s1_op", res_op1, 7);
    chk("s1_hot_e1", hotselect1, 0);
    res_ready1 = 1'b1;
    @(negedge clk);
    chk("s1_ready_after", cmd_ready1, 1);

    // Random traffic against the model.
    @(negedge clk);
    cmd_valid = 1'b0; res_ready = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < SN; i++) tbl[i] = $urandom;
    tbl[3]  = 32'h0;
    tbl[12] = 32'hF000_0000;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #2;
      cmd_valid = ($urandom % 2) == 0;
      cmd_op    = OW'($urandom);
      res_ready = ($urandom % 10) < 6;
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("end_idle", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
